// File: rtl/ddram_burst_ctrl.sv
// Avalon-MM DDR3 bridge: edge-triggered read bursts into NCH line buffers and
// multi-beat write bursts from a flat line input, with write-first arbitration.
module ddram_burst_ctrl #(
  parameter int         NCH      = 2,
  parameter int         MAXBURST = 15,
  parameter logic [5:0] BASE_HI  = 6'b000111,
  localparam int        CW       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int        LW       = 64 * MAXBURST
) (
  input  logic            DDRAM_CLK,
  input  logic            DDRAM_RESET_N,
  input  logic            DDRAM_BUSY,
  output logic [7:0]      DDRAM_BURSTCNT,
  output logic [28:0]     DDRAM_ADDR,
  input  logic [63:0]     DDRAM_DOUT,
  input  logic            DDRAM_DOUT_READY,
  output logic            DDRAM_RD,
  output logic [63:0]     DDRAM_DIN,
  output logic [7:0]      DDRAM_BE,
  output logic            DDRAM_WE,
  input  logic [27:1]     mem_addr,
  input  logic [7:0]      mem_burst,
  input  logic [CW-1:0]   mem_ch,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [7:0]      mem_be,
  input  logic [LW-1:0]   mem_din,
  input  logic [CW-1:0]   mem_dout_ch,
  output logic [LW-1:0]   mem_dout,
  output logic [63:0]     mem_dout_first,
  output logic            mem_busy,
  output logic            mem_dready,
  output logic            mem_wdone
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WR     = 2'd1;
  localparam logic [1:0] S_RD_CMD = 2'd2;
  localparam logic [1:0] S_RD_DAT = 2'd3;
  localparam logic [7:0] MAXB     = 8'(MAXBURST);

  function automatic logic [7:0] clamp_burst(input logic [7:0] b);
    logic [7:0] r;
    r = (b == 8'd0) ? 8'd1 : ((b > MAXB) ? MAXB : b);
    return r;
  endfunction

  function automatic logic [63:0] beat_sel(input logic [LW-1:0] line, input logic [7:0] k);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < MAXBURST; i++) begin
      r = (k == 8'(i)) ? line[64*i +: 64] : r;
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic          rd_d1_q, rd_d1_d, wr_d1_q, wr_d1_d;
  logic          rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [28:0]   addr_q, addr_d;
  logic [7:0]    bc_q, bc_d;
  logic [7:0]    be_q, be_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [7:0]    idx_q, idx_d;
  logic [63:0]   din_q, din_d;
  logic          rd_q, rd_d, we_q, we_d;
  logic          dready_q, dready_d, wdone_q, wdone_d, busy_q, busy_d;
  logic          buf_we_s, rd_clr_s, wr_clr_s, rd_rise_s, wr_rise_s, last_s;
  logic [LW-1:0] buf_q [NCH];
  logic [63:0]   first_q;
  logic          unused_s;

  assign unused_s = ^{mem_addr[27:26], mem_addr[2:1]};

  // Next-state: edge capture, arbitration and burst sequencing.
  always_comb begin
    state_d   = state_q;
    rd_d1_d   = mem_rd;
    wr_d1_d   = mem_wr;
    addr_d    = addr_q;
    bc_d      = bc_q;
    be_d      = be_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    din_d     = din_q;
    rd_d      = rd_q;
    we_d      = we_q;
    dready_d  = 1'b0;
    wdone_d   = 1'b0;
    buf_we_s  = 1'b0;
    rd_clr_s  = 1'b0;
    wr_clr_s  = 1'b0;
    rd_rise_s = mem_rd & ~rd_d1_q;
    wr_rise_s = mem_wr & ~wr_d1_q;
    last_s    = (idx_q == (bc_q - 8'd1));
    case (state_q)
      S_IDLE: begin
        if (wr_req_q) begin
          state_d = S_WR;
          we_d    = 1'b1;
          addr_d  = {BASE_HI, mem_addr[25:3]};
          bc_d    = clamp_burst(mem_burst);
          be_d    = mem_be;
          idx_d   = 8'd0;
          din_d   = mem_din[63:0];
        end else if (rd_req_q) begin
          state_d = S_RD_CMD;
          rd_d    = 1'b1;
          addr_d  = {BASE_HI, mem_addr[25:3]};
          bc_d    = clamp_burst(mem_burst);
          be_d    = 8'hFF;
          ch_d    = mem_ch;
          idx_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (we_q && !DDRAM_BUSY) begin
          if (last_s) begin
            we_d     = 1'b0;
            wdone_d  = 1'b1;
            wr_clr_s = 1'b1;
            be_d     = 8'hFF;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
            din_d = beat_sel(mem_din, idx_q + 8'd1);
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_RD_CMD: begin
        if (!DDRAM_BUSY) begin
          rd_d    = 1'b0;
          state_d = S_RD_DAT;
        end else begin
          rd_d = 1'b1;
        end
      end
      S_RD_DAT: begin
        // Read beats are valid regardless of waitrequest.
        if (DDRAM_DOUT_READY) begin
          buf_we_s = 1'b1;
          if (last_s) begin
            dready_d = 1'b1;
            rd_clr_s = 1'b1;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          state_d = S_RD_DAT;
        end
      end
      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
    rd_req_d = rd_req_q ? ~rd_clr_s : rd_rise_s;
    wr_req_d = wr_req_q ? ~wr_clr_s : wr_rise_s;
    busy_d   = rd_req_d | wr_req_d | (state_d != S_IDLE);
  end

  // Control and bus-side registers.
  always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
    if (!DDRAM_RESET_N) begin
      state_q  <= S_IDLE;
      rd_d1_q  <= 1'b0;
      wr_d1_q  <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q   <= 29'd0;
      bc_q     <= 8'd1;
      be_q     <= 8'hFF;
      ch_q     <= '0;
      idx_q    <= 8'd0;
      din_q    <= 64'd0;
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      dready_q <= 1'b0;
      wdone_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_d1_q  <= rd_d1_d;
      wr_d1_q  <= wr_d1_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      addr_q   <= addr_d;
      bc_q     <= bc_d;
      be_q     <= be_d;
      ch_q     <= ch_d;
      idx_q    <= idx_d;
      din_q    <= din_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      dready_q <= dready_d;
      wdone_q  <= wdone_d;
      busy_q   <= busy_d;
    end
  end

  // Line buffers keep their contents across reset; only the active channel is written.
  always_ff @(posedge DDRAM_CLK) begin
    if (buf_we_s) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < MAXBURST; k++) begin
          if (ch_q == CW'(c) && idx_q == 8'(k)) begin
            buf_q[c][64*k +: 64] <= DDRAM_DOUT;
          end
        end
      end
      if (idx_q == 8'd0) begin
        first_q <= DDRAM_DOUT;
      end
    end
  end

  assign DDRAM_BURSTCNT = bc_q;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_WE       = we_q;
  assign mem_dout       = buf_q[mem_dout_ch];
  assign mem_dout_first = first_q;
  assign mem_busy       = busy_q;
  assign mem_dready     = dready_q;
  assign mem_wdone      = wdone_q;

endmodule

// File: tb/tb_ddram_burst_ctrl.sv
// Directed bench for ddram_burst_ctrl: write-beat scoreboard queue plus a
// line-buffer model, responding to the Avalon bus from the bench side.
module tb_ddram_burst_ctrl;
  localparam int NCH  = 2;
  localparam int MAXB = 15;
  localparam int LW   = 64 * MAXB;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ddr_busy;
  logic [7:0]      ddr_burstcnt;
  logic [28:0]     ddr_addr;
  logic [63:0]     ddr_dout;
  logic            ddr_dout_ready;
  logic            ddr_rd;
  logic [63:0]     ddr_din;
  logic [7:0]      ddr_be;
  logic            ddr_we;
  logic [27:1]     mem_addr;
  logic [7:0]      mem_burst;
  logic            mem_ch;
  logic            mem_rd;
  logic            mem_wr;
  logic [7:0]      mem_be;
  logic [LW-1:0]   mem_din;
  logic            mem_dout_ch;
  logic [LW-1:0]   mem_dout;
  logic [63:0]     mem_dout_first;
  logic            mem_busy;
  logic            mem_dready;
  logic            mem_wdone;

  always #5 clk = ~clk;

  ddram_burst_ctrl #(.NCH(NCH), .MAXBURST(MAXB), .BASE_HI(6'b000111)) dut (
    .DDRAM_CLK(clk), .DDRAM_RESET_N(rst_n), .DDRAM_BUSY(ddr_busy),
    .DDRAM_BURSTCNT(ddr_burstcnt), .DDRAM_ADDR(ddr_addr), .DDRAM_DOUT(ddr_dout),
    .DDRAM_DOUT_READY(ddr_dout_ready), .DDRAM_RD(ddr_rd), .DDRAM_DIN(ddr_din),
    .DDRAM_BE(ddr_be), .DDRAM_WE(ddr_we), .mem_addr(mem_addr), .mem_burst(mem_burst),
    .mem_ch(mem_ch), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be),
    .mem_din(mem_din), .mem_dout_ch(mem_dout_ch), .mem_dout(mem_dout),
    .mem_dout_first(mem_dout_first), .mem_busy(mem_busy), .mem_dready(mem_dready),
    .mem_wdone(mem_wdone)
  );

  int total = 0;
  int bad = 0;
  logic [63:0] wr_sb[$];
  logic [63:0] model [NCH][MAXB];
  logic [63:0] first_exp;
  logic [28:0] exp_waddr, exp_raddr;
  logic [7:0]  exp_wbc, exp_rbc, exp_be;
  int cur_ch;
  int dready_cnt, wdone_cnt, acc_cnt, rdacc_cnt;
  int rd_at, we_at, dready_at, wdone_at, busy_fall;
  logic busy_at_wdone;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input bit rd, input bit wr, input logic [27:1] addr, input logic [7:0] burst,
                        input int nexp, input int ch, input logic [7:0] be, input logic [63:0] wpat);
    @(negedge clk);
    mem_addr  = addr;
    mem_burst = burst;
    mem_ch    = 1'(ch);
    mem_be    = be;
    if (wr) begin
      for (int k = 0; k < MAXB; k++) mem_din[64*k +: 64] = wpat + 64'(k);
      for (int k = 0; k < nexp; k++) wr_sb.push_back(wpat + 64'(k));
      exp_waddr = {6'b000111, addr[25:3]};
      exp_wbc   = 8'(nexp);
      exp_be    = be;
    end
    if (rd) begin
      exp_raddr = {6'b000111, addr[25:3]};
      exp_rbc   = 8'(nexp);
      cur_ch    = ch;
    end
    mem_rd = rd;
    mem_wr = wr;
  endtask

  // Bus responder: answers commands, feeds read beats, pops write beats; bounded by max_cyc.
  task automatic serve(input int max_cyc, input bit toggle, input int rn, input logic [63:0] rpat,
                       input int extra, input int re_rd_at, input int stop_beat);
    int k;
    bit feeding;
    k = 0; feeding = 1'b0;
    dready_cnt = 0; wdone_cnt = 0; acc_cnt = 0; rdacc_cnt = 0;
    rd_at = -1; we_at = -1; dready_at = -1; wdone_at = -1; busy_fall = -1; busy_at_wdone = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      mem_rd = (c == re_rd_at);
      mem_wr = 1'b0;
      if (mem_dready) begin dready_cnt++; dready_at = c; end
      if (mem_wdone) begin wdone_cnt++; wdone_at = c; busy_at_wdone = mem_busy; end
      if (!mem_busy && busy_fall < 0) busy_fall = c;
      if (ddr_rd && rd_at < 0) rd_at = c;
      if (ddr_we && we_at < 0) we_at = c;
      ddr_busy = toggle ? ((c % 2) == 1) : 1'b0;
      if (ddr_we) begin
        chk("wr_burstcnt", ddr_burstcnt, exp_wbc);
        chk("wr_addr", ddr_addr, exp_waddr);
        chk("wr_be", ddr_be, exp_be);
      end
      if (ddr_we && !ddr_busy) begin
        acc_cnt++;
        if (wr_sb.size() > 0) chk("wr_din", ddr_din, wr_sb.pop_front());
      end
      if (feeding) begin
        if (k == stop_beat) break;
        if (k < rn + extra) begin
          ddr_dout_ready = 1'b1;
          ddr_dout = rpat + 64'(k);
          if (k < rn) model[cur_ch][k] = rpat + 64'(k);
          if (k == 0) first_exp = rpat;
          k++;
        end else begin
          ddr_dout_ready = 1'b0;
          ddr_dout = 64'd0;
        end
      end
      if (ddr_rd && !ddr_busy) begin
        rdacc_cnt++;
        feeding = 1'b1;
        chk("rd_addr", ddr_addr, exp_raddr);
        chk("rd_burstcnt", ddr_burstcnt, exp_rbc);
        chk("rd_be", ddr_be, 64'hFF);
      end
    end
    ddr_busy = 1'b0;
  endtask

  task automatic check_buf(input int ch);
    @(negedge clk);
    ddr_dout_ready = 1'b0;
    mem_dout_ch = 1'(ch);
    #1;
    for (int k = 0; k < MAXB; k++)
      chk($sformatf("buf%0d_beat%0d", ch, k), mem_dout[64*k +: 64], model[ch][k]);
    chk("dout_first", mem_dout_first, first_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ddr_busy = 1'b0; ddr_dout = 64'd0; ddr_dout_ready = 1'b0;
    mem_addr = '0; mem_burst = 8'd0; mem_ch = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_be = 8'd0; mem_din = '0; mem_dout_ch = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd", ddr_rd, 64'd0);
    chk("rst_we", ddr_we, 64'd0);
    chk("rst_burstcnt", ddr_burstcnt, 64'd1);
    chk("rst_be", ddr_be, 64'hFF);
    chk("rst_din", ddr_din, 64'd0);
    chk("rst_busy", mem_busy, 64'd0);
    chk("rst_dready", mem_dready, 64'd0);
    chk("rst_wdone", mem_wdone, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // full read into buffer 0, latency and busy timing
    launch(1'b1, 1'b0, 27'h0123458, 8'd15, 15, 0, 8'h00, 64'd0);
    serve(40, 1'b0, 15, 64'hA0A0_0000_0000_0000, 0, -1, -1);
    chk("rd0_latency", rd_at, 64'd1);
    chk("rd0_dready_cnt", dready_cnt, 64'd1);
    chk("rd0_cmd_cnt", rdacc_cnt, 64'd1);
    chk("rd0_busy_fall", busy_fall, dready_at);
    check_buf(0);

    // full read into buffer 1; buffer 0 must be untouched
    launch(1'b1, 1'b0, 27'h2ABCDE8, 8'd15, 15, 1, 8'h00, 64'd0);
    serve(40, 1'b0, 15, 64'hB1B1_0000_0000_0000, 0, -1, -1);
    chk("rd1_dready_cnt", dready_cnt, 64'd1);
    check_buf(1);
    check_buf(0);

    // 4-beat write with waitrequest toggling
    launch(1'b0, 1'b1, 27'h0000100, 8'd4, 4, 0, 8'h0F, 64'hC0DE_0000_0000_0000);
    serve(40, 1'b1, 0, 64'd0, 0, -1, -1);
    chk("wr4_latency", we_at, 64'd1);
    chk("wr4_beats", acc_cnt, 64'd4);
    chk("wr4_wdone_cnt", wdone_cnt, 64'd1);
    chk("wr4_sb_empty", wr_sb.size(), 64'd0);
    chk("wr4_busy_end", mem_busy, 64'd0);

    // simultaneous read and write requests: write first, busy held until dready
    launch(1'b1, 1'b1, 27'h0345670, 8'd3, 3, 0, 8'hF0, 64'hD00D_0000_0000_0000);
    serve(60, 1'b0, 3, 64'hE0E0_0000_0000_0000, 0, -1, -1);
    chk("both_wdone_cnt", wdone_cnt, 64'd1);
    chk("both_dready_cnt", dready_cnt, 64'd1);
    chk("both_wr_beats", acc_cnt, 64'd3);
    chk("both_write_first", (we_at >= 0) && (we_at < rd_at), 64'd1);
    chk("both_busy_at_wdone", busy_at_wdone, 64'd1);
    chk("both_busy_after_dready", (dready_at >= 0) && (busy_fall >= dready_at), 64'd1);
    check_buf(0);

    // burst 0 becomes a single beat
    launch(1'b0, 1'b1, 27'h0000040, 8'd0, 1, 0, 8'hFF, 64'h1111_0000_0000_0000);
    serve(30, 1'b0, 0, 64'd0, 0, -1, -1);
    chk("b0_beats", acc_cnt, 64'd1);
    chk("b0_wdone_cnt", wdone_cnt, 64'd1);

    // burst 200 clamps to MAXBURST, read held by waitrequest
    launch(1'b1, 1'b0, 27'h1000000, 8'd200, 15, 1, 8'h00, 64'd0);
    serve(50, 1'b1, 15, 64'h2222_0000_0000_0000, 0, -1, -1);
    chk("b200_dready_cnt", dready_cnt, 64'd1);
    check_buf(1);

    // short read followed by stray beats that must be ignored
    launch(1'b1, 1'b0, 27'h0000200, 8'd4, 4, 1, 8'h00, 64'd0);
    serve(30, 1'b0, 4, 64'h3333_0000_0000_0000, 2, -1, -1);
    chk("x4_dready_cnt", dready_cnt, 64'd1);
    check_buf(1);

    // reset during beat 7 aborts the read
    launch(1'b1, 1'b0, 27'h0000400, 8'd15, 15, 0, 8'h00, 64'd0);
    serve(40, 1'b0, 15, 64'h4444_0000_0000_0000, 0, -1, 7);
    ddr_dout_ready = 1'b1; ddr_dout = 64'h4444_0000_0000_0007; rst_n = 1'b0;
    #1;
    chk("arst_rd", ddr_rd, 64'd0);
    chk("arst_we", ddr_we, 64'd0);
    chk("arst_busy", mem_busy, 64'd0);
    chk("arst_dready", mem_dready, 64'd0);
    @(negedge clk); ddr_dout_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    serve(6, 1'b0, 0, 64'd0, 0, -1, -1);
    chk("arst_no_dready", dready_cnt, 64'd0);
    chk("arst_no_cmd", rdacc_cnt, 64'd0);
    launch(1'b1, 1'b0, 27'h0000800, 8'd15, 15, 0, 8'h00, 64'd0);
    serve(40, 1'b0, 15, 64'h5555_0000_0000_0000, 0, -1, -1);
    chk("post_rst_dready_cnt", dready_cnt, 64'd1);
    check_buf(0);

    // second read edge while a read is active is dropped
    launch(1'b1, 1'b0, 27'h0001000, 8'd3, 3, 0, 8'h00, 64'd0);
    serve(40, 1'b0, 3, 64'h6666_0000_0000_0000, 0, 3, -1);
    chk("dup_dready_cnt", dready_cnt, 64'd1);
    chk("dup_cmd_cnt", rdacc_cnt, 64'd1);
    chk("dup_busy_end", mem_busy, 64'd0);
    check_buf(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
